// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter handing a single shared slave bus to one of NUM_M masters, with wait timeout.
// Latency: grant is registered one edge after request; owner hand-over has no idle bubble; slave path is combinational.
// Backpressure: s_rdy_ high stalls the owner; TMO stalled cycles revoke its grant and pulse tmo_ low.
module bus_rr_arbiter #(
   parameter int NUM_M  = 4,
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32,
   parameter int TMO    = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_M-1:0]         m_req_,
   input  logic [NUM_M*ADDR_W-1:0]  m_addr,
   input  logic [NUM_M-1:0]         m_as_,
   input  logic [NUM_M-1:0]         m_rw,
   input  logic [NUM_M*DATA_W-1:0]  m_wr_data,
   output logic [NUM_M-1:0]         m_grnt_,
   input  logic                     s_rdy_,
   output logic [ADDR_W-1:0]        s_addr,
   output logic                     s_as_,
   output logic                     s_rw,
   output logic [DATA_W-1:0]        s_wr_data,
   output logic [$clog2(NUM_M)-1:0] owner,
   output logic                     busy,
   output logic                     tmo_
);

   localparam int               OW      = $clog2(NUM_M);
   localparam bit               TMO_EN  = (TMO != 0);
   localparam logic [15:0]      TMO_LIM = 16'(TMO);
   localparam logic [NUM_M-1:0] ONE     = {{(NUM_M-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

   state_t           state;
   logic [OW-1:0]    ptr;
   logic [15:0]      wait_cnt;

   logic [NUM_M-1:0] req;
   logic [NUM_M-1:0] req_eff;
   logic [OW:0]      cand;
   logic             arb_found;
   logic [OW-1:0]    arb_idx;
   logic [OW:0]      nxt_sum;
   logic [OW-1:0]    arb_nxt;
   logic             owner_rel;
   logic             tmo_hit;

   assign busy = (state == OWN);
   assign req  = ~m_req_;

   // While owning, the current owner is never a candidate: either it released or it timed out.
   // Since ptr is always owner+1 in OWN, scanning from ptr is the same as scanning from owner+1.
   assign req_eff = busy ? (req & ~(ONE << owner)) : req;

   // Scan requests from ptr upward with wrap-around; the first requester found wins.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_M; k++) begin
         cand = {1'b0, ptr} + (OW+1)'(k);
         if (cand >= (OW+1)'(NUM_M)) begin
            cand = cand - (OW+1)'(NUM_M);
         end
         if (!arb_found && req_eff[cand[OW-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = cand[OW-1:0];
         end
      end
   end

   assign nxt_sum   = {1'b0, arb_idx} + (OW+1)'(1);
   assign arb_nxt   = (nxt_sum == (OW+1)'(NUM_M)) ? '0 : nxt_sum[OW-1:0];
   assign owner_rel = m_req_[owner];
   assign tmo_hit   = TMO_EN && (wait_cnt == TMO_LIM);

   // Route the owner's bus signals to the slave; park them in a harmless state when nobody owns the bus.
   always_comb begin
      s_addr    = '0;
      s_wr_data = '0;
      s_as_     = 1'b1;
      s_rw      = 1'b1;
      if (busy) begin
         s_addr    = m_addr[int'(owner)*ADDR_W +: ADDR_W];
         s_wr_data = m_wr_data[int'(owner)*DATA_W +: DATA_W];
         s_as_     = m_as_[owner];
         s_rw      = m_rw[owner];
      end
   end

   // Grant FSM: issue grants, hand over on release or timeout, and run the owner's wait counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         m_grnt_  <= '1;
         owner    <= '0;
         ptr      <= '0;
         tmo_     <= 1'b1;
         wait_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               tmo_     <= 1'b1;
               wait_cnt <= '0;
               if (arb_found) begin
                  state   <= OWN;
                  owner   <= arb_idx;
                  m_grnt_ <= ~(ONE << arb_idx);
                  ptr     <= arb_nxt;
               end
            end
            OWN: begin
               if (owner_rel || tmo_hit) begin
                  // A voluntary release in the same cycle as a timeout is not reported as a timeout.
                  tmo_     <= owner_rel;
                  wait_cnt <= '0;
                  if (arb_found) begin
                     owner   <= arb_idx;
                     m_grnt_ <= ~(ONE << arb_idx);
                     ptr     <= arb_nxt;
                  end else begin
                     state   <= IDLE;
                     m_grnt_ <= '1;
                  end
               end else begin
                  tmo_ <= 1'b1;
                  if (TMO_EN) begin
                     if (!s_rdy_) begin
                        wait_cnt <= '0;
                     end else if (!s_as_) begin
                        wait_cnt <= wait_cnt + 16'd1;
                     end
                  end
               end
            end
            default: begin
               state   <= IDLE;
               m_grnt_ <= '1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
module tb_bus_rr_arbiter;

   localparam int N   = 4;
   localparam int AW  = 30;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    m_req_;
   logic [N*AW-1:0] m_addr;
   logic [N-1:0]    m_as_;
   logic [N-1:0]    m_rw;
   logic [N*DW-1:0] m_wr_data;
   logic [N-1:0]    m_grnt_;
   logic            s_rdy_;
   logic [AW-1:0]   s_addr;
   logic            s_as_;
   logic            s_rw;
   logic [DW-1:0]   s_wr_data;
   logic [1:0]      owner;
   logic            busy;
   logic            tmo_;

   bus_rr_arbiter #(.NUM_M(N), .ADDR_W(AW), .DATA_W(DW), .TMO(TMO)) dut (
      .clk(clk), .reset(reset), .m_req_(m_req_), .m_addr(m_addr), .m_as_(m_as_),
      .m_rw(m_rw), .m_wr_data(m_wr_data), .m_grnt_(m_grnt_), .s_rdy_(s_rdy_),
      .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data),
      .owner(owner), .busy(busy), .tmo_(tmo_)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   // reference model state: owner index (-1 = nobody), rotation start, wait count, timeout pulse
   int   m_own  = -1;
   int   m_ptr  = 0;
   int   m_wait = 0;
   logic m_tmo  = 1'b1;

   int starve [N];
   int prev_own = -1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // first requester at or after start (cyclically), skipping excl
   function automatic int pick(input int start, input int excl, input logic [N-1:0] rq_n);
      for (int k = 0; k < N; k++) begin
         if (!rq_n[(start + k) % N] && ((start + k) % N) != excl) return (start + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_grnt();
      if (m_own < 0) return '1;
      return ~(N'(1) << m_own);
   endfunction

   function automatic int dut_own();
      for (int i = 0; i < N; i++) begin
         if (!m_grnt_[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_next();
      int n;
      bit rel;
      bit fire;
      if (m_own < 0) begin
         m_tmo = 1'b1;
         n = pick(m_ptr, -1, m_req_);
         if (n >= 0) begin
            m_own  = n;
            m_ptr  = (n + 1) % N;
            m_wait = 0;
         end
      end else begin
         rel  = m_req_[m_own];
         fire = (m_wait == TMO);
         if (rel || fire) begin
            m_tmo  = rel;
            m_wait = 0;
            n = pick((m_own + 1) % N, m_own, m_req_);
            if (n >= 0) begin
               m_own = n;
               m_ptr = (n + 1) % N;
            end else begin
               m_own = -1;
            end
         end else begin
            m_tmo = 1'b1;
            if (!s_rdy_) m_wait = 0;
            else if (!m_as_[m_own]) m_wait++;
         end
      end
   endtask

   task automatic check_slave();
      if (m_own < 0) begin
         chk("s_as_idle", s_as_, 1);
         chk("s_rw_idle", s_rw, 1);
         chk("s_addr_idle", s_addr, 0);
         chk("s_data_idle", s_wr_data, 0);
      end else begin
         chk("s_as", s_as_, m_as_[m_own]);
         chk("s_rw", s_rw, m_rw[m_own]);
         chk("s_addr", s_addr, m_addr[m_own*AW +: AW]);
         chk("s_data", s_wr_data, m_wr_data[m_own*DW +: DW]);
      end
   endtask

   task automatic check_regs();
      int d;
      chk("grnt", m_grnt_, exp_grnt());
      chk("busy", busy, (m_own >= 0));
      chk("tmo_", tmo_, m_tmo);
      if (m_own >= 0) chk("owner", owner, m_own);
      chk("onecold", ($countones(~m_grnt_) <= 1), 1);
      d = dut_own();
      if (d >= 0 && d != prev_own) begin
         for (int i = 0; i < N; i++) begin
            if (i == d) starve[i] = 0;
            else if (!m_req_[i]) begin
               starve[i]++;
               chk("starve", (starve[i] <= N - 1), 1);
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         if (m_req_[i]) starve[i] = 0;
      end
      prev_own = d;
   endtask

   // one clock: check combinational outputs, advance the model, check registered outputs after the edge
   task automatic step();
      #1;
      check_slave();
      model_next();
      @(posedge clk);
      #1;
      check_regs();
   endtask

   task automatic model_reset();
      m_own = -1; m_ptr = 0; m_wait = 0; m_tmo = 1'b1; prev_own = -1;
      for (int i = 0; i < N; i++) starve[i] = 0;
   endtask

   task automatic rand_inputs();
      for (int i = 0; i < N; i++) begin
         if (i == m_own) begin
            if ($urandom_range(0, 15) == 0) m_req_[i] = 1'b1;
         end else if (m_req_[i]) begin
            if ($urandom_range(0, 3) == 0) m_req_[i] = 1'b0;
         end
         m_as_[i] = ($urandom_range(0, 7) == 0);
         m_rw[i]  = 1'($urandom_range(0, 1));
         m_addr[i*AW +: AW]    = AW'($urandom);
         m_wr_data[i*DW +: DW] = $urandom;
      end
      s_rdy_ = ($urandom_range(0, 7) != 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b0;
      m_req_ = '1;
      m_as_  = '1;
      m_rw   = '0;
      s_rdy_ = 1'b1;
      for (int i = 0; i < N; i++) begin
         m_addr[i*AW +: AW]    = AW'($urandom);
         m_wr_data[i*DW +: DW] = $urandom;
      end
      model_reset();

      // reset state
      #12;
      chk("rst_grnt", m_grnt_, 4'b1111);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_tmo", tmo_, 1);
      chk("rst_s_as", s_as_, 1);
      chk("rst_s_rw", s_rw, 1);
      chk("rst_s_addr", s_addr, 0);
      chk("rst_s_data", s_wr_data, 0);

      // everyone requests: master 0 wins one edge later
      @(negedge clk);
      reset  = 1'b1;
      m_req_ = 4'b0000;
      #1 chk("no_grant_before_edge", m_grnt_, 4'b1111);
      step();
      chk("first_grant", m_grnt_, 4'b1110);
      chk("first_owner", owner, 0);
      chk("first_busy", busy, 1);

      // master 0 releases, masters 1 and 3 request: direct hand-over to 1
      m_req_ = 4'b0101;
      step();
      chk("handover", m_grnt_, 4'b1101);

      // master 1 releases, only master 0 requests: wrap-around
      m_req_ = 4'b1110;
      step();
      chk("wrap", m_grnt_, 4'b1110);

      // hand to master 2
      m_req_ = 4'b1011;
      step();
      chk("own2", m_grnt_, 4'b1011);

      // owner 2 stalls with strobe low and slave not ready; master 3 also requests
      m_req_ = 4'b0011;
      m_as_  = 4'b1011;
      s_rdy_ = 1'b1;
      repeat (TMO) step();
      chk("tmo_hold_grnt", m_grnt_, 4'b1011);
      chk("tmo_hold_pulse", tmo_, 1);
      step();
      chk("tmo_revoke_grnt", m_grnt_, 4'b0111);
      chk("tmo_pulse", tmo_, 0);
      step();
      chk("tmo_pulse_end", tmo_, 1);

      // owner 3 stalls until timeout, then releases in the firing cycle: no pulse
      m_as_ = 4'b0111;
      repeat (TMO) step();
      m_req_ = 4'b1011;
      step();
      chk("rel_beats_tmo", tmo_, 1);
      chk("rel_beats_tmo_grnt", m_grnt_, 4'b1011);

      // asynchronous reset while busy, away from any edge
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_grnt", m_grnt_, 4'b1111);
      chk("async_rst_s_as", s_as_, 1);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_tmo", tmo_, 1);
      model_reset();
      @(posedge clk);
      #1 chk("rst_hold_grnt", m_grnt_, 4'b1111);
      @(negedge clk);
      reset  = 1'b1;
      m_req_ = 4'b0011;
      #1 chk("rst_release_no_grant", m_grnt_, 4'b1111);
      step();
      chk("post_rst_grant", m_grnt_, 4'b1011);

      // randomized traffic against the model
      for (int c = 0; c < 10000; c++) begin
         rand_inputs();
         step();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
Parameters:
REQ-001 SHALL have parameter NUM_M, default 4: number of bus masters, 2..16.
REQ-002 SHALL have parameter ADDR_W, default 30: word address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width.
REQ-004 SHALL have parameter TMO, default 255: wait-cycle timeout limit, 1..65535; 0 disables the timeout.

Ports (name, direction, width, meaning):
REQ-005 SHALL have port clk, in, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, in, 1: asynchronous, active-low reset.
REQ-007 SHALL have port m_req_, in, NUM_M: per-master bus request, active-low.
REQ-008 SHALL have port m_addr, in, NUM_M*ADDR_W: packed master addresses; master i occupies [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port m_as_, in, NUM_M: per-master address strobe, active-low.
REQ-010 SHALL have port m_rw, in, NUM_M: per-master read/write select (1=read, 0=write).
REQ-011 SHALL have port m_wr_data, in, NUM_M*DATA_W: packed master write data.
REQ-012 SHALL have port m_grnt_, out, NUM_M: registered, one-cold bus grant.
REQ-013 SHALL have port s_rdy_, in, 1: ready from the slave side, active-low.
REQ-014 SHALL have port s_addr, out, ADDR_W: address of the owning master.
REQ-015 SHALL have port s_as_, out, 1: strobe of the owning master.
REQ-016 SHALL have port s_rw, out, 1: read/write of the owning master.
REQ-017 SHALL have port s_wr_data, out, DATA_W: write data of the owning master.
REQ-018 SHALL have port owner, out, clog2(NUM_M): index of the current owner; valid when busy=1.
REQ-019 SHALL have port busy, out, 1: high while any grant is asserted.
REQ-020 SHALL have port tmo_, out, 1: one-cycle active-low pulse when a grant is revoked by timeout.

Function
REQ-021 SHALL have exactly two states: IDLE (no grant) and OWN (exactly one grant low).
REQ-022 SHALL, in IDLE with any m_req_ low, grant the first requester found by scanning from index ptr upward with wrap-around; grant appears on the next edge; no grant if no request.
REQ-023 SHALL keep ptr = (last owner + 1) mod NUM_M, updated whenever a grant is issued; ptr resets to 0.
REQ-024 SHALL, in OWN, hold the grant while the owner's m_req_ stays low; requests from other masters do not preempt.
REQ-025 SHALL, in OWN when the owner's m_req_ goes high, re-arbitrate in the same cycle starting from owner+1: the next requester's grant appears on the next edge with no idle bubble; go to IDLE if nobody requests.
REQ-026 SHALL assert at most one m_grnt_ bit low in every cycle; all grants high in IDLE.
REQ-027 SHALL drive the slave outputs combinationally from the registered owner while busy=1.
REQ-028 SHALL, when busy=0, drive s_as_=1, s_rw=1, s_addr=0 and s_wr_data=0.
REQ-029 SHALL, when TMO != 0, run a 16-bit wait counter that increments in OWN while s_as_=0 and s_rdy_=1, and clears on s_rdy_=0, on any grant change, and in IDLE.
REQ-030 SHALL, when the wait counter reaches TMO, revoke the grant on the next edge, pulse tmo_ low for that one cycle, and re-arbitrate per REQ-025 while excluding the timed-out master for that arbitration only.
REQ-031 SHALL give owner-release precedence over timeout when both occur in the same cycle: no tmo_ pulse.

Reset
REQ-032 SHALL, while reset=0 (asynchronous), drive m_grnt_ to all ones, busy=0, owner=0, tmo_=1, ptr=0, wait counter 0 and state IDLE, with slave outputs per REQ-028.
REQ-033 SHALL, on reset assertion mid-transfer, drop the grant immediately without waiting for a clock edge.
REQ-034 SHALL grant nothing until the first rising edge after reset deasserts.

Verification (NUM_M=4, TMO=8)
REQ-035 SHALL cover: after reset, m_req_=4'b0000 -> m_grnt_=4'b1110 one edge later, owner=0, busy=1.
REQ-036 SHALL cover: master 0 releases while masters 1 and 3 request -> m_grnt_=4'b1101 on the next edge, with no idle cycle.
REQ-037 SHALL cover: master 1 releases while only master 0 requests -> wrap-around, m_grnt_=4'b1110.
REQ-038 SHALL cover: owner 2 holds s_as_=0 with s_rdy_=1 for 8 cycles -> grant revoked, tmo_ low for exactly 1 cycle, and master 3 (if requesting) granted even though master 2 still requests.
REQ-039 SHALL cover: reset pulled low while busy -> m_grnt_=4'b1111 and s_as_=1 within the same cycle, before any clock edge.
REQ-040 SHALL cover: random requests for 10k cycles -> assertions hold (one-cold grant; no master starved beyond NUM_M-1 foreign tenures).
